// File: rtl/car_parking_pkg.sv
// Shared types and parameter defaults for the car-park entry gate controller.
package car_parking_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    WRONG_PASS = 3'd2,
    RIGHT_PASS = 3'd3,
    STOP       = 3'd4
  } state_t;

  localparam int WAIT_CYCLES_DEFAULT = 4;
  localparam int BLINK_HALF_DEFAULT  = 8;

endpackage

// File: rtl/car_parking_blink.sv
// Square-wave generator for the alert LED; compiled only when CAR_PARKING_BLINK_EN
// is defined. Restart forces the output high and the phase counter to zero.
`ifdef CAR_PARKING_BLINK_EN
module car_parking_blink #(
  parameter int BLINK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic blink
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (restart) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == HALF_LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule
`endif

// File: rtl/car_parking_gate_fsm.sv
// Moore controller for a single-lane car-park entry gate driving three LEDs.
// Define CAR_PARKING_BLINK_EN to make led_alert blink in WRONG_PASS and STOP.
module car_parking_gate_fsm
  import car_parking_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int BLINK_HALF  = BLINK_HALF_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_entrace,
  input  logic sensor_exit,
  input  logic password,
  output logic led_alert,
  output logic led_available,
  output logic led_wait
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("WAIT_CYCLES must be at least 1");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be at least 1");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            alert_on;

  // NOTE: every signal written here is given a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      IDLE: begin
        if (sensor_entrace) state_d = WAIT_PASS;
      end
      WAIT_PASS: begin
        if (wait_cnt_q < WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d = password ? RIGHT_PASS : WRONG_PASS;
        end
      end
      WRONG_PASS: begin
        if (password) state_d = RIGHT_PASS;
      end
      RIGHT_PASS: begin
        if (sensor_entrace && sensor_exit) state_d = STOP;
        else if (sensor_exit)              state_d = IDLE;
      end
      STOP: begin
        if (password) state_d = RIGHT_PASS;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef CAR_PARKING_BLINK_EN
  logic blink;

  // Blink phase restarts on every state change so each alert episode starts lit.
  car_parking_blink #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state_d != state_q),
    .enable  ((state_q == WRONG_PASS) || (state_q == STOP)),
    .blink   (blink)
  );

  assign alert_on = blink;
`else
  assign alert_on = 1'b1;
`endif

  always_comb begin
    led_alert     = 1'b0;
    led_available = 1'b0;
    led_wait      = 1'b0;
    case (state_q)
      WAIT_PASS:  led_wait      = 1'b1;
      WRONG_PASS: led_alert     = alert_on;
      RIGHT_PASS: led_available = 1'b1;
      STOP: begin
        led_alert = alert_on;
        led_wait  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_car_parking_gate_fsm.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each
// cycle against an LED-pattern model of the gate.
module tb_car_parking_gate_fsm;

  localparam int WAIT_CYCLES = 4;
  localparam int BLINK_HALF  = 8;

  // LED patterns as {alert, available, wait}
  localparam logic [2:0] L_IDLE  = 3'b000;
  localparam logic [2:0] L_WAIT  = 3'b001;
  localparam logic [2:0] L_WRONG = 3'b100;
  localparam logic [2:0] L_RIGHT = 3'b010;
  localparam logic [2:0] L_STOP  = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ent = 1'b0;
  logic ex = 1'b0;
  logic pw = 1'b0;
  logic led_alert, led_available, led_wait;
  logic chk_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  car_parking_gate_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BLINK_HALF  (BLINK_HALF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensor_entrace (ent),
    .sensor_exit    (ex),
    .password       (pw),
    .led_alert      (led_alert),
    .led_available  (led_available),
    .led_wait       (led_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: leds {alert,avail,wait} got %b expected %b", name, $time, act, exp);
  endtask

  // Reference model: the visible LED pattern plus edges left before the decision
  logic [2:0] m_leds;
  int         m_left;
  int         m_age;

  function automatic logic [2:0] model_next(input logic [2:0] cur, input int left,
                                            input logic e, input logic x, input logic p);
    if (cur == L_IDLE)  return e ? L_WAIT : L_IDLE;
    if (cur == L_WAIT)  return (left > 0) ? L_WAIT : (p ? L_RIGHT : L_WRONG);
    if (cur == L_WRONG) return p ? L_RIGHT : L_WRONG;
    if (cur == L_STOP)  return p ? L_RIGHT : L_STOP;
    if (cur == L_RIGHT) return (e && x) ? L_STOP : (x ? L_IDLE : L_RIGHT);
    return L_IDLE;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_leds <= L_IDLE;
      m_left <= 0;
      m_age  <= 0;
    end else begin
      m_leds <= model_next(m_leds, m_left, ent, ex, pw);
      if (m_leds == L_IDLE && ent)          m_left <= WAIT_CYCLES - 1;
      else if (m_leds == L_WAIT && m_left > 0) m_left <= m_left - 1;
      else                                   m_left <= 0;
      m_age <= (model_next(m_leds, m_left, ent, ex, pw) != m_leds) ? 0 : m_age + 1;
    end
  end

  function automatic logic [2:0] expected_leds();
`ifdef CAR_PARKING_BLINK_EN
    return {m_leds[2] & (((m_age / BLINK_HALF) % 2) == 0), m_leds[1:0]};
`else
    return m_leds;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) check("cycle", {led_alert, led_available, led_wait}, expected_leds());
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hold", {led_alert, led_available, led_wait}, 3'b000);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {led_alert, led_available, led_wait}, 3'b000);

    // Wrong password, then correct one
    ent = 1'b1; pw = 1'b0;
    for (int i = 0; i < WAIT_CYCLES; i++) begin
      @(negedge clk);
      check("wait_led", {led_alert, led_available, led_wait}, 3'b001);
    end
    @(negedge clk);
    check("wrong_alert", {led_alert, led_available, led_wait}, 3'b100);
    ent = 1'b0; pw = 1'b1;
    @(negedge clk);
    check("right_after_wrong", {led_alert, led_available, led_wait}, 3'b010);

    // Exit and hold exit in IDLE
    pw = 1'b0; ex = 1'b1;
    @(negedge clk);
    check("exit_idle", {led_alert, led_available, led_wait}, 3'b000);
    repeat (2) begin
      @(negedge clk);
      check("exit_hold", {led_alert, led_available, led_wait}, 3'b000);
    end

    // Direct grant: available on the fifth edge counting the sampling edge
    ex = 1'b0; ent = 1'b1; pw = 1'b1;
    for (int i = 0; i < WAIT_CYCLES; i++) begin
      @(negedge clk);
      check("grant_wait", {led_alert, led_available, led_wait}, 3'b001);
    end
    @(negedge clk);
    check("direct_grant", {led_alert, led_available, led_wait}, 3'b010);

    // Blocked second car, then released by password
    ex = 1'b1; pw = 1'b0;
    @(negedge clk);
    check("blocked", {led_alert, led_available, led_wait}, 3'b101);
    ent = 1'b0; ex = 1'b0; pw = 1'b1;
    @(negedge clk);
    check("unblock", {led_alert, led_available, led_wait}, 3'b010);

    // Asynchronous reset in RIGHT_PASS, observed between clock edges
    pw = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", {led_alert, led_available, led_wait}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_async", {led_alert, led_available, led_wait}, 3'b000);

    // Randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ent = ($urandom_range(0, 2) == 0);
      ex  = ($urandom_range(0, 2) == 0);
      pw  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_reset", {led_alert, led_available, led_wait}, 3'b000);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
